proc_sequencer: RTL and testbench

Multi-cycle control unit for the 8-register, 4-bit bus processor datapath. Accepts one 9-bit instruction per `run` request, decodes it and over 2 or 4 clock steps drives the datapath's bus-select multiplexers, register load enables and ALU controls. It also raises `done` on the final step. It is the only source of select lines for the 8:1 register-read multiplexer and the bus-source multiplexers, so no other block drives the shared bus.

---
 rtl/proc_sequencer.sv | 132 +++++++++++++
 tb/tb_proc_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/proc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : proc_sequencer
// Description : Multi-cycle control unit for the 8-register, 4-bit bus
//               processor; steps T0..T3 and drives datapath selects/enables.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_sequencer #(
    parameter int NREG = 8,
    parameter int IW   = 9
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic [IW-1:0]     instr,
    output logic              ir_ld,
    output logic [2:0]        rsel,
    output logic [1:0]        bus_src,
    output logic [NREG-1:0]   r_in,
    output logic              a_in,
    output logic              g_in,
    output logic              addsub,
    output logic              done,
    output logic              busy
);

    localparam logic [1:0] c_bus_reg = 2'b00;
    localparam logic [1:0] c_bus_din = 2'b01;
    localparam logic [1:0] c_bus_g   = 2'b10;

    localparam logic [2:0] c_op_mv  = 3'b000;
    localparam logic [2:0] c_op_mvi = 3'b001;
    localparam logic [2:0] c_op_add = 3'b010;
    localparam logic [2:0] c_op_sub = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    step_t          r_step;
    step_t          w_step_nxt;
    logic [IW-1:0]  r_ir;

    logic [2:0]     w_op;
    logic [2:0]     w_rx;
    logic [2:0]     w_ry;
    logic [NREG-1:0] w_rx_onehot;

    assign w_op        = r_ir[8:6];
    assign w_rx        = r_ir[5:3];
    assign w_ry        = r_ir[2:0];
    assign w_rx_onehot = NREG'(1) << w_rx;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_step <= T0;
            r_ir   <= '0;
        end else begin
            r_step <= w_step_nxt;
            if (ir_ld) begin
                r_ir <= instr;
            end
        end
    end

    // ir_ld is gated by resetn so every output is 0 while reset is held.
    always_comb begin
        w_step_nxt = r_step;
        ir_ld      = 1'b0;
        rsel       = 3'd0;
        bus_src    = c_bus_reg;
        r_in       = '0;
        a_in       = 1'b0;
        g_in       = 1'b0;
        addsub     = 1'b0;
        done       = 1'b0;
        busy       = (r_step != T0);

        case (r_step)
            T0: begin
                if (run && resetn) begin
                    ir_ld      = 1'b1;
                    w_step_nxt = T1;
                end
            end
            T1: begin
                case (w_op)
                    c_op_mv: begin
                        rsel       = w_ry;
                        r_in       = w_rx_onehot;
                        done       = 1'b1;
                        w_step_nxt = T0;
                    end
                    c_op_mvi: begin
                        bus_src    = c_bus_din;
                        r_in       = w_rx_onehot;
                        done       = 1'b1;
                        w_step_nxt = T0;
                    end
                    c_op_add, c_op_sub: begin
                        rsel       = w_rx;
                        a_in       = 1'b1;
                        w_step_nxt = T2;
                    end
                    default: begin
                        // Reserved opcodes retire as a NOP.
                        done       = 1'b1;
                        w_step_nxt = T0;
                    end
                endcase
            end
            T2: begin
                rsel       = w_ry;
                g_in       = 1'b1;
                addsub     = w_op[0];
                w_step_nxt = T3;
            end
            T3: begin
                bus_src    = c_bus_g;
                r_in       = w_rx_onehot;
                done       = 1'b1;
                w_step_nxt = T0;
            end
            default: w_step_nxt = T0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_proc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_sequencer
// Description : Scoreboard bench for proc_sequencer with a per-instruction
//               reference model producing the expected cycle-by-cycle outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_sequencer;

    logic       clock;
    logic       resetn;
    logic       run;
    logic [8:0] instr;
    logic       ir_ld;
    logic [2:0] rsel;
    logic [1:0] bus_src;
    logic [7:0] r_in;
    logic       a_in;
    logic       g_in;
    logic       addsub;
    logic       done;
    logic       busy;

    proc_sequencer #(.NREG(8), .IW(9)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .run     (run),
        .instr   (instr),
        .ir_ld   (ir_ld),
        .rsel    (rsel),
        .bus_src (bus_src),
        .r_in    (r_in),
        .a_in    (a_in),
        .g_in    (g_in),
        .addsub  (addsub),
        .done    (done),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_vec;
    int         n_bad;
    bit         mon_en;
    int         busy_left;
    logic [18:0] exp_q[$];

    function automatic logic [18:0] pack(input logic ld, input logic [2:0] sel,
                                         input logic [1:0] src, input logic [7:0] rin,
                                         input logic a, input logic g, input logic sub,
                                         input logic dn, input logic bz);
        return {ld, sel, src, rin, a, g, sub, dn, bz};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {ir_ld, rsel, bus_src, r_in, a_in, g_in, addsub, done, busy};
    endfunction

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an instruction is a capture cycle followed by a list
    // of bus transfers, each described by source, destination and ALU action.
    task automatic model_push(input logic [8:0] ins);
        logic [2:0] op;
        logic [2:0] x;
        logic [2:0] y;
        logic [7:0] dst;
        op  = ins[8:6];
        x   = ins[5:3];
        y   = ins[2:0];
        dst = 8'(1 << x);
        exp_q.push_back(pack(1'b1, 3'd0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (op == 3'd0) begin
            exp_q.push_back(pack(1'b0, y, 2'b00, dst, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        end else if (op == 3'd1) begin
            exp_q.push_back(pack(1'b0, 3'd0, 2'b01, dst, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        end else if (op == 3'd2 || op == 3'd3) begin
            exp_q.push_back(pack(1'b0, x, 2'b00, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
            exp_q.push_back(pack(1'b0, y, 2'b00, 8'd0, 1'b0, 1'b1, (op == 3'd3), 1'b0, 1'b1));
            exp_q.push_back(pack(1'b0, 3'd0, 2'b10, dst, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        end else begin
            exp_q.push_back(pack(1'b0, 3'd0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        end
    endtask

    function automatic int model_len(input logic [8:0] ins);
        return (ins[8:6] == 3'd2 || ins[8:6] == 3'd3) ? 4 : 2;
    endfunction

    // Called just after a rising edge; drives one cycle of inputs.
    task automatic drive_cycle(input logic rn, input logic [8:0] ins);
        run   = rn;
        instr = ins;
        if (busy_left == 0) begin
            if (rn) begin
                model_push(ins);
                busy_left = model_len(ins) - 1;
            end
        end else begin
            busy_left--;
        end
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (ir_ld || busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_activity", dut_vec(), 19'd0);
                end else begin
                    check("step", dut_vec(), exp_q.pop_front());
                end
            end else begin
                check("idle", dut_vec(), 19'd0);
            end
        end
    end

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        mon_en    = 1'b0;
        busy_left = 0;
        resetn    = 1'b0;
        run       = 1'b1;
        instr     = 9'b010_000_001;

        // Reset held with run high: everything quiet.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("reset_hold", dut_vec(), 19'd0);
            instr = 9'($urandom);
        end

        // Asynchronous abort during T2 of an add.
        @(negedge clock);
        resetn = 1'b1;
        run    = 1'b1;
        instr  = 9'b010_000_001;
        @(posedge clock);
        #1;
        run = 1'b0;
        @(posedge clock);
        #2;
        check("pre_abort_T2", dut_vec(),
              pack(1'b0, 3'd1, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        resetn = 1'b0;
        #1;
        check("async_abort", dut_vec(), 19'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check("after_abort_idle", dut_vec(), 19'd0);

        // Directed sequences under the scoreboard.
        mon_en = 1'b1;
        drive_cycle(1'b1, 9'b001_011_000);
        drive_cycle(1'b0, 9'd0);
        drive_cycle(1'b0, 9'd0);
        drive_cycle(1'b1, 9'b000_101_110);
        drive_cycle(1'b0, 9'd0);
        drive_cycle(1'b1, 9'b011_001_111);
        drive_cycle(1'b0, 9'b000_111_111);
        drive_cycle(1'b0, 9'b001_000_000);
        drive_cycle(1'b0, 9'd0);
        // add R0,R1 then mv R3,R0 with run held; instr scrambled mid-add.
        drive_cycle(1'b1, 9'b010_000_001);
        drive_cycle(1'b1, 9'b111_111_111);
        drive_cycle(1'b1, 9'b001_110_101);
        drive_cycle(1'b1, 9'b000_011_000);
        drive_cycle(1'b1, 9'b000_011_000);
        drive_cycle(1'b1, 9'b000_011_000);
        drive_cycle(1'b0, 9'd0);
        drive_cycle(1'b1, 9'b110_010_010);
        drive_cycle(1'b0, 9'd0);
        drive_cycle(1'b0, 9'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), 9'($urandom));
        end

        // Drain, bounded.
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 9'd0);
        end
        @(negedge clock);
        mon_en = 1'b0;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
